// File: rtl/reg_poll_mon_if.sv
// reg_poll_mon_if
// Simple single-outstanding register bus used between the polling monitor
// (master) and the register bridge (slave).
//   bus_req   : master -> slave, transfer request, held until bus_ack
//   bus_we    : master -> slave, 1 = write, 0 = read
//   bus_addr  : master -> slave, byte address (AW bits)
//   bus_wdata : master -> slave, write data (DW bits)
//   bus_ack   : slave -> master, single-cycle completion pulse
//   bus_rdata : slave -> master, read data, valid while bus_ack = 1
interface reg_poll_mon_if #(
  parameter int AW = 32,
  parameter int DW = 32
) ();

  logic          bus_req;
  logic          bus_we;
  logic [AW-1:0] bus_addr;
  logic [DW-1:0] bus_wdata;
  logic          bus_ack;
  logic [DW-1:0] bus_rdata;

  modport master (
    output bus_req,
    output bus_we,
    output bus_addr,
    output bus_wdata,
    input  bus_ack,
    input  bus_rdata
  );

  modport slave (
    input  bus_req,
    input  bus_we,
    input  bus_addr,
    input  bus_wdata,
    output bus_ack,
    output bus_rdata
  );

endinterface

// File: rtl/reg_poll_mon.sv
// reg_poll_mon
// Multi-channel register poller. Walks the channels round-robin, reads each
// channel's status register and, when its valid bit is set, reads NWORDS data
// words, clears the status register and queues {channel, packet} in a
// first-word-fall-through output FIFO. Valid packets that arrive while the
// FIFO is full are left uncleared and counted in missCount.
// Ports:
//   rclk, rstn     : clock, asynchronous active-low reset
//   enable         : polling enable (sampled in IDLE and WAIT only)
//   pollingDelay   : idle cycles inserted after each channel poll
//   bus            : register bus master port (reg_poll_mon_if.master)
//   pValid/pReady  : output FIFO head handshake
//   pData, pChan   : head packet (word i at [i*DW +: DW]) and its channel
//   missCount      : saturating count of skipped valid packets
//   fifoLevel      : output FIFO occupancy
module reg_poll_mon #(
  parameter int          NCH       = 2,
  parameter int          NWORDS    = 8,
  parameter int          DW        = 32,
  parameter int          AW        = 32,
  parameter int          DEPTH     = 4,
  parameter logic [31:0] CH_STRIDE = 32'h100,
  parameter logic [31:0] STAT_OFF  = 32'h4,
  parameter logic [31:0] DATA_OFF  = 32'h10,
  localparam int         CW        = (NCH > 1) ? $clog2(NCH) : 1,
  localparam int         LW        = $clog2(DEPTH) + 1
) (
  input  logic                 rclk,
  input  logic                 rstn,
  input  logic                 enable,
  input  logic [31:0]          pollingDelay,
  reg_poll_mon_if.master       bus,
  output logic                 pValid,
  input  logic                 pReady,
  output logic [NWORDS*DW-1:0] pData,
  output logic [CW-1:0]        pChan,
  output logic [15:0]          missCount,
  output logic [LW-1:0]        fifoLevel
);

  localparam int IW = (NWORDS > 1) ? $clog2(NWORDS) : 1;
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [2:0] {
    IDLE,
    RD_STAT,
    RD_DATA,
    WR_CLR,
    PUSH,
    WAIT
  } state_t;

  state_t               state;
  logic [CW-1:0]        chan_ptr;
  logic [CW-1:0]        next_chan;
  logic [IW-1:0]        word_idx;
  logic [31:0]          delay_cnt;
  logic [NWORDS*DW-1:0] staging;

  logic                 req_q;
  logic                 we_q;
  logic [AW-1:0]        addr_q;
  logic [DW-1:0]        wdata_q;

  logic [AW-1:0]        base_addr;
  logic [AW-1:0]        stat_addr;
  logic [AW-1:0]        data_addr;

  logic [NWORDS*DW-1:0] fifo_data [DEPTH];
  logic [CW-1:0]        fifo_chan [DEPTH];
  logic [PW-1:0]        wr_ptr;
  logic [PW-1:0]        rd_ptr;
  logic                 fifo_full;
  logic                 push;
  logic                 pop;

  assign bus.bus_req   = req_q;
  assign bus.bus_we    = we_q;
  assign bus.bus_addr  = addr_q;
  assign bus.bus_wdata = wdata_q;

  // Register addresses of the channel currently pointed at.
  assign base_addr = AW'(chan_ptr) * AW'(CH_STRIDE);
  assign stat_addr = base_addr + AW'(STAT_OFF);
  assign data_addr = base_addr + AW'(DATA_OFF) + AW'(word_idx) * AW'(DW / 8);

  assign next_chan = (chan_ptr == CW'(NCH - 1)) ? '0 : chan_ptr + CW'(1);

  assign fifo_full = (fifoLevel == LW'(DEPTH));
  assign push      = (state == PUSH);
  assign pop       = pValid && pReady;

  // Polling sequencer. Each bus state first raises the request (entered with
  // req low), then waits for the ack; the request is dropped on the ack edge
  // so every transfer takes at least two cycles and never overlaps the next.
  // The full/miss decision is taken at the status ack, and since only PUSH
  // writes the FIFO while pops only free space, a started packet always fits.
  always_ff @(posedge rclk or negedge rstn) begin
    if (!rstn) begin
      state     <= IDLE;
      chan_ptr  <= '0;
      word_idx  <= '0;
      delay_cnt <= '0;
      staging   <= '0;
      req_q     <= 1'b0;
      we_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      missCount <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (enable) state <= RD_STAT;
        end
        RD_STAT: begin
          if (!req_q) begin
            req_q  <= 1'b1;
            we_q   <= 1'b0;
            addr_q <= stat_addr;
          end else if (bus.bus_ack) begin
            req_q <= 1'b0;
            if (bus.bus_rdata[0] && !fifo_full) begin
              word_idx <= '0;
              state    <= RD_DATA;
            end else begin
              if (bus.bus_rdata[0] && (missCount != 16'hFFFF))
                missCount <= missCount + 16'd1;
              chan_ptr  <= next_chan;
              delay_cnt <= pollingDelay;
              state     <= WAIT;
            end
          end
        end
        RD_DATA: begin
          if (!req_q) begin
            req_q  <= 1'b1;
            we_q   <= 1'b0;
            addr_q <= data_addr;
          end else if (bus.bus_ack) begin
            req_q <= 1'b0;
            staging[word_idx*DW +: DW] <= bus.bus_rdata;
            if (word_idx == IW'(NWORDS - 1))
              state <= WR_CLR;
            else
              word_idx <= word_idx + IW'(1);
          end
        end
        WR_CLR: begin
          if (!req_q) begin
            req_q   <= 1'b1;
            we_q    <= 1'b1;
            addr_q  <= stat_addr;
            wdata_q <= '0;
          end else if (bus.bus_ack) begin
            req_q <= 1'b0;
            we_q  <= 1'b0;
            state <= PUSH;
          end
        end
        PUSH: begin
          chan_ptr  <= next_chan;
          delay_cnt <= pollingDelay;
          state     <= WAIT;
        end
        WAIT: begin
          if (delay_cnt == 32'd0)
            state <= enable ? RD_STAT : IDLE;
          else
            delay_cnt <= delay_cnt - 32'd1;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Output FIFO storage and occupancy. Push and pop in the same cycle both
  // take effect and leave the level unchanged; pointers wrap naturally since
  // DEPTH is a power of two. Storage is reset so the head reads as zero.
  always_ff @(posedge rclk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < DEPTH; i++) begin
        fifo_data[i] <= '0;
        fifo_chan[i] <= '0;
      end
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      fifoLevel <= '0;
    end else begin
      if (push) begin
        fifo_data[wr_ptr] <= staging;
        fifo_chan[wr_ptr] <= chan_ptr;
        wr_ptr            <= wr_ptr + PW'(1);
      end
      if (pop)
        rd_ptr <= rd_ptr + PW'(1);
      if (push && !pop)
        fifoLevel <= fifoLevel + LW'(1);
      else if (pop && !push)
        fifoLevel <= fifoLevel - LW'(1);
    end
  end

  assign pValid = (fifoLevel != '0);
  assign pData  = fifo_data[rd_ptr];
  assign pChan  = fifo_chan[rd_ptr];

endmodule

// File: doc/reg_poll_mon.md
Name: reg_poll_mon

Overview:
- Synthesizable, multi-channel successor to the testbench register monitor.
- Acts as a simple register-bus master: polls each channel's status register in round-robin order.
- When a channel's valid bit is set, reads NWORDS data words, clears the status register, and pushes {channel, packet} into an output FIFO with a valid/ready interface.
- Sits between the AHB-side register bridge and the checker/consumer logic. Missed or back-pressured polls are counted rather than printed.

Parameters:
- NCH, 2: number of polled channels (1..16)
- NWORDS, 8: data words per packet
- DW, 32: bus data width
- AW, 32: bus address width
- DEPTH, 4: output FIFO depth in packets (power of 2, >=2)
- CH_STRIDE, 32'h100: address stride between channel register blocks
- STAT_OFF, 32'h4: status register offset; bit0 is valid
- DATA_OFF, 32'h10: first data word offset; words are consecutive at +DW/8

Ports:
- rclk, input, 1: register-domain clock
- rstn, input, 1: asynchronous active-low reset
- enable, input, 1: polling enable
- pollingDelay, input, 32: idle cycles inserted after each channel poll
- bus_req, output, 1: bus transfer request
- bus_we, output, 1: 1=write, 0=read
- bus_addr, output, AW: transfer address
- bus_wdata, output, DW: write data
- bus_ack, input, 1: transfer complete, single-cycle pulse
- bus_rdata, input, DW: read data, valid when bus_ack=1
- pValid, output, 1: FIFO head valid
- pReady, input, 1: consumer accepts head
- pData, output, NWORDS*DW: head packet; word i at [i*DW +: DW]
- pChan, output, CW: head channel index; CW = max(1, clog2(NCH))
- missCount, output, 16: saturating count of skipped valid packets
- fifoLevel, output, clog2(DEPTH)+1: FIFO occupancy

Behaviour:
- Clocking and reset:
  - Single clock, rclk. rstn is asynchronous and active-low.
  - Reset values: FSM=IDLE, channel pointer=0, bus_req=0, bus_we=0, bus_addr=0, bus_wdata=0, FIFO empty, pValid=0, pData=0, pChan=0, missCount=0, fifoLevel=0.
  - Reset mid-transfer aborts immediately; the bus slave must tolerate a dropped request.
- Bus handshake:
  - bus_req, bus_we, bus_addr and bus_wdata are registered and held stable until the cycle bus_ack=1 is sampled.
  - bus_req drops on the following edge. Every transfer costs at least 2 cycles.
  - Only one transfer is outstanding at a time.
- Channel c base address = c*CH_STRIDE.
- FSM states:
  - IDLE: if enable, go to RD_STAT.
  - RD_STAT: read base+STAT_OFF. On ack:
    - rdata[0]=0: go to WAIT.
    - rdata[0]=1 and fifoLevel==DEPTH: increment missCount (saturates at 16'hFFFF), leave status uncleared, go to WAIT.
    - rdata[0]=1 otherwise: word index=0, go to RD_DATA.
  - RD_DATA: read base+DATA_OFF+idx*(DW/8). On ack, store into staging[idx]. When idx==NWORDS-1, go to WR_CLR; otherwise idx++.
  - WR_CLR: write 0 to base+STAT_OFF. On ack, go to PUSH.
  - PUSH: write {c, staging} into the FIFO in one cycle, go to WAIT.
  - WAIT:
    - On entry: channel pointer advances (wraps NCH-1 -> 0) and the delay counter loads pollingDelay.
    - Counter decrements each cycle. At 0: if enable, go to RD_STAT; else go to IDLE.
    - pollingDelay=0: WAIT lasts exactly 1 cycle.
- enable is sampled only in IDLE and WAIT. A packet sequence that has started always completes.
- FIFO full is decided at RD_STAT ack. Only PUSH writes the FIFO and pops only free space, so a push never overflows.
- FIFO:
  - First-word-fall-through. pValid = (fifoLevel != 0). pData/pChan show the head.
  - Pop when pValid && pReady.
  - A push to an empty FIFO makes pValid=1 on the next edge (1-cycle latency from PUSH).
  - Simultaneous push and pop: level is unchanged and both take effect.
  - pReady while empty is ignored.
  - Pointers wrap modulo DEPTH.
- Minimum poll-to-push latency with zero-wait bus: 2 + 2*NWORDS + 2 + 1 cycles.

Test Plan:
- Reset/idle: assert rstn low mid-RD_DATA -> all outputs zero immediately; after release with enable=0, bus_req stays 0 for 100 cycles.
- Single packet: NCH=2, ch1 status=1, data words 0x11..0x88, pReady=1 -> reads 0x104 then 0x110..0x12C, write 0 to 0x104, then pValid pulses 1 cycle with pChan=1 and pData word0=0x11, word7=0x88.
- Round-robin and delay: pollingDelay=5, no valid -> status reads alternate 0x004, 0x104; successive bus_req rises separated by exactly 5+1+2 cycles with zero-wait ack.
- Back-pressure: DEPTH=4, pReady=0, ch0 always valid -> 4 packets queued (fifoLevel=4), then each further ch0 poll increments missCount by 1 with no data reads or clear write; pReady=1 drains 4 packets in order.
- Simultaneous push/pop: fifoLevel=2, pReady=1 held during PUSH -> fifoLevel stays 2, head advances, data order preserved.
- Enable drop: deassert enable during RD_DATA word 3 -> remaining words, clear write and push complete; FSM then goes IDLE with no further bus_req.
